fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter for the dual-clock async FIFO, in the wclk domain.
//  Shares the single FIFO write port (wreq/wdata/wfull) between N_REQ requesters.
//  Uses burst-granular grants and per-requester valid/ready handshakes.
//  Holds a grant for a burst, stalls on wfull, and releases on last beat, burst cap or idle timeout.
// PARAMETERS
//  N_REQ      4   number of requesters (2..8)
//  DW         8   data width; matches the FIFO wdata width
//  MAX_BURST  4   max beats per grant (1..16)
//  TIMEOUT    8   idle cycles inside a burst before forced release (>=1)
// PORTS
//  wclk         in   1         write-domain clock
//  wrst_n       in   1         reset, asynchronous, active-low
//  arb_en       in   1         1 = new grants allowed; 0 = finish current burst, then hold IDLE
//  req_valid    in   N_REQ     per-requester beat valid
//  req_last     in   N_REQ     per-requester last-beat-of-burst marker, qualified by valid
//  req_data     in   N_REQ*DW  per-requester data; requester i uses bits [i*DW +: DW]
//  req_ready    out  N_REQ     per-requester beat accepted this cycle
//  fifo_wreq    out  1         FIFO write request
//  fifo_wdata   out  DW        FIFO write data
//  fifo_wfull   in   1         FIFO full flag, registered, from the wclk domain
//  grant_id     out  clog2(N)  index of the current owner; valid while busy=1
//  busy         out  1         1 = in BURST state
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=N_REQ-1, grant_id=0, beat_cnt=0, idle_cnt=0.
//    busy=0, req_ready=0, fifo_wreq=0. fifo_wdata=0 while not busy.
//  Reset mid-burst: burst is abandoned and no partial state is kept.
//  FSM, two states:
//   IDLE: if arb_en & |req_valid, pick the first valid index after rr_ptr, wrapping modulo N_REQ.
//     Register it in grant_id, clear the counters, and go to BURST.
//     Arbitration costs 1 cycle. No transfer happens in IDLE.
//   BURST: xfer = req_valid[g] & ~fifo_wfull, where g = grant_id.
//     req_ready[g] = xfer. All other req_ready bits = 0.
//     fifo_wreq = xfer (combinational). fifo_wdata = req_data[g] (combinational mux).
//     On xfer: beat_cnt++ and idle_cnt cleared.
//     Release to IDLE, setting rr_ptr=g, on xfer with req_last[g] or beat_cnt==MAX_BURST-1.
//     Without xfer: if req_valid[g]=0, idle_cnt++. If idle_cnt==TIMEOUT-1, release as above.
//     A wfull stall does not advance idle_cnt; only a missing req_valid[g] does.
//  fifo_wreq is never asserted while fifo_wfull=1. This is a hard rule and is not
//    left to the FIFO's internal gating.
//  Fairness: after a release, the released requester has lowest priority at the next arbitration.
//  arb_en has no effect on a burst in progress. A burst re-entered from IDLE always costs 1 bubble cycle.
//  req_last on a non-transfer cycle is ignored.
//  beat_cnt is clog2(MAX_BURST)+1 bits wide and never wraps, because release occurs at the cap.
//  Throughput: at most MAX_BURST beats per MAX_BURST+1 cycles when never full.
// STRUCTURE
//  Shared package fifo_pkg: state enum {IDLE, BURST}, FIFO_DW=8.
//  Sub-module rr_picker: combinational round-robin first-one-after-pointer search.
//    Inputs: req vector and rr_ptr. Outputs: grant index and any_req.
//    Reused by the read-side scheduler.
//  Top level holds the FSM, counters and the data mux. No other sub-modules.
// TESTING
//  1. All 4 requesters valid, 1-beat bursts with last=1, wfull=0.
//     -> grants 0,1,2,3,0 in order, one beat every 2 cycles.
//  2. Req 2 streams 10 beats without last, MAX_BURST=4.
//     -> released after beats 4 and 8, and re-granted because it is the only requester.
//     -> all 10 data values are written in order.
//  3. wfull=1 for 5 cycles mid-burst.
//     -> fifo_wreq=0 and req_ready=0 throughout; idle_cnt holds; the burst resumes with no lost beat.
//  4. Owner drops valid for 8 cycles, TIMEOUT=8.
//     -> busy falls after cycle 8; the next valid requester is granted one cycle later.
//  5. arb_en=0 during a burst.
//     -> the burst completes; no new grant while arb_en=0; the grant resumes 1 cycle after arb_en=1.
//  6. wrst_n asserted mid-burst.
//     -> all outputs 0 immediately; after release, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the async FIFO write/read side logic
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int FIFO_DW = 8;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search for the first request after ptr
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    logic [IW-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest one after ptr wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst-granular round-robin arbiter for the FIFO write port
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = FIFO_DW,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic                     arb_en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     fifo_wreq,
    output logic [DW-1:0]            fifo_wdata,
    input  logic                     fifo_wfull,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int GW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick;
    logic          any_req;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] idle_cnt;
    logic          xfer;
    logic [DW-1:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    rr_picker #(
        .N  (N_REQ),
        .IW (GW)
    ) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    assign busy = (state == BURST);
    // A full FIFO blocks the beat here rather than relying on the FIFO to drop it.
    assign xfer      = busy & req_valid[grant_id] & ~fifo_wfull;
    assign fifo_wreq = xfer;

    always_comb begin
        req_ready  = '0;
        fifo_wdata = '0;
        if (busy) begin
            req_ready[grant_id] = xfer;
            fifo_wdata          = data_arr[grant_id];
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            rr_ptr   <= GW'(N_REQ - 1);
            grant_id <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en && any_req) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        idle_cnt <= '0;
                        if (req_last[grant_id] || beat_cnt == BW'(MAX_BURST - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= grant_id;
                        end
                    end else if (!req_valid[grant_id]) begin
                        // Only an absent owner counts toward the timeout; a full stall does not.
                        if (idle_cnt == TW'(TIMEOUT - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= grant_id;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wreq;
    logic [7:0]  fifo_wdata;
    logic        fifo_wfull;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Reference model: owner index (-1 when idle), beats and idle cycles counted naturally.
    int m_owner, m_beats, m_idle, m_ptr;
    logic       e_busy, e_wreq;
    logic [3:0] e_ready;
    logic [7:0] e_wdata;
    logic [1:0] e_gid;

    fifo_wr_arbiter dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .arb_en     (arb_en),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wreq  (fifo_wreq),
        .fifo_wdata (fifo_wdata),
        .fifo_wfull (fifo_wfull),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 wclk = ~wclk;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_beats = 0;
        m_idle  = 0;
    endfunction

    function automatic void model_eval();
        int g;
        e_busy  = (m_owner >= 0);
        e_ready = '0;
        e_wreq  = 1'b0;
        e_wdata = '0;
        e_gid   = '0;
        if (e_busy) begin
            g       = m_owner;
            e_gid   = g[1:0];
            e_wreq  = req_valid[g[1:0]] && !fifo_wfull;
            if (e_wreq) e_ready[g[1:0]] = 1'b1;
            e_wdata = 8'(req_data >> (8 * g));
        end
    endfunction

    function automatic void model_clock();
        int g;
        int idx;
        bit found;
        if (m_owner < 0) begin
            found = 0;
            if (arb_en) begin
                for (int k = 1; k <= 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (!found && req_valid[idx[1:0]]) begin
                        found   = 1;
                        m_owner = idx;
                        m_beats = 0;
                        m_idle  = 0;
                    end
                end
            end
        end else begin
            g = m_owner;
            if (req_valid[g[1:0]] && !fifo_wfull) begin
                m_beats++;
                m_idle = 0;
                if (req_last[g[1:0]] || m_beats == 4) begin
                    m_ptr = g;
                    m_owner = -1;
                end
            end else if (!req_valid[g[1:0]]) begin
                m_idle++;
                if (m_idle == 8) begin
                    m_ptr = g;
                    m_owner = -1;
                end
            end
        end
    endfunction

    task automatic sample();
        @(negedge wclk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge wclk);
        model_clock();
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        req_last  = '0;
        fifo_wfull = 1'b0;
        for (int i = 0; i < 20 && m_owner >= 0; i++) advance();
    endtask

    task automatic test_reset();
        wrst_n = 1'b0; arb_en = 1'b1; req_valid = 4'hF; req_last = 4'hF;
        req_data = 32'hA5A5_A5A5; fifo_wfull = 1'b0;
        model_reset();
        repeat (3) @(posedge wclk);
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'h0 || fifo_wreq !== 1'b0 || fifo_wdata !== 8'h00 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want all zero",
                     busy, req_ready, fifo_wreq, fifo_wdata, grant_id);
        end
        wrst_n = 1'b1; req_valid = '0; req_last = '0;
        for (int c = 0; c < 2; c++) begin
            sample();
            checks++;
            if (busy !== e_busy || req_ready !== e_ready || fifo_wreq !== e_wreq || fifo_wdata !== e_wdata || (e_busy && grant_id !== e_gid) || (fifo_wreq && fifo_wfull)) begin
                failures++;
                $display("FAIL reset_idle: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want busy=%b ready=%b wreq=%b wdata=%h gid=%0d",
                         busy, req_ready, fifo_wreq, fifo_wdata, grant_id, e_busy, e_ready, e_wreq, e_wdata, e_gid);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int writes = 0;
        int last_cyc = -1;
        arb_en = 1'b1; req_valid = 4'hF; req_last = 4'hF; fifo_wfull = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req_data = $urandom;
            sample();
            checks++;
            if (busy !== e_busy || req_ready !== e_ready || fifo_wreq !== e_wreq || fifo_wdata !== e_wdata || (e_busy && grant_id !== e_gid) || (fifo_wreq && fifo_wfull)) begin
                failures++;
                $display("FAIL rr_cycle: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want busy=%b ready=%b wreq=%b wdata=%h gid=%0d",
                         busy, req_ready, fifo_wreq, fifo_wdata, grant_id, e_busy, e_ready, e_wreq, e_wdata, e_gid);
            end
            if (fifo_wreq && writes < 5) begin
                checks++;
                if (int'(grant_id) != exp_seq[writes] || (writes > 0 && c - last_cyc != 2)) begin
                    failures++;
                    $display("FAIL rr_order: write %0d got gid=%0d gap=%0d want gid=%0d gap=2",
                             writes, grant_id, c - last_cyc, exp_seq[writes]);
                end
                last_cyc = c;
                writes++;
            end
            advance();
        end
        checks++;
        if (writes != 5) begin
            failures++;
            $display("FAIL rr_count: got %0d writes want 5", writes);
        end
    endtask

    task automatic test_stream_cap();
        logic [7:0] wr_q[$];
        int rel_q[$];
        int beat = 0;
        logic prev_busy = 1'b0;
        drain();
        req_last = '0;
        for (int c = 0; c < 30; c++) begin
            req_valid = (beat < 10) ? 4'b0100 : 4'b0000;
            req_data  = (32'h20 + 32'(beat)) << 16;
            sample();
            checks++;
            if (busy !== e_busy || req_ready !== e_ready || fifo_wreq !== e_wreq || fifo_wdata !== e_wdata || (e_busy && grant_id !== e_gid) || (fifo_wreq && fifo_wfull)) begin
                failures++;
                $display("FAIL stream_cycle: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want busy=%b ready=%b wreq=%b wdata=%h gid=%0d",
                         busy, req_ready, fifo_wreq, fifo_wdata, grant_id, e_busy, e_ready, e_wreq, e_wdata, e_gid);
            end
            if (fifo_wreq) begin
                wr_q.push_back(fifo_wdata);
                beat++;
            end
            if (prev_busy && !busy) rel_q.push_back(beat);
            prev_busy = busy;
            advance();
        end
        checks++;
        if (wr_q.size() != 10) begin
            failures++;
            $display("FAIL stream_count: got %0d beats want 10", wr_q.size());
        end
        for (int i = 0; i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== 8'(8'h20 + i)) begin
                failures++;
                $display("FAIL stream_data: beat %0d got %h want %h", i, wr_q[i], 8'(8'h20 + i));
            end
        end
        checks++;
        if (rel_q.size() != 3 || rel_q[0] != 4 || rel_q[1] != 8 || rel_q[2] != 10) begin
            failures++;
            $display("FAIL stream_release: got %0d releases first at beats %0d,%0d want 4,8,10",
                     rel_q.size(), (rel_q.size() > 0) ? rel_q[0] : -1, (rel_q.size() > 1) ? rel_q[1] : -1);
        end
    endtask

    task automatic test_wfull_stall();
        logic [7:0] wr_q[$];
        int beat = 0;
        drain();
        req_last = '0;
        for (int c = 0; c < 19; c++) begin
            req_valid  = ((c < 2 || (c >= 8 && c <= 12) || c >= 14) && c < 17) ? 4'b0010 : 4'b0000;
            fifo_wfull = (c >= 8 && c <= 12);
            req_data   = (32'h40 + 32'(beat)) << 8;
            sample();
            checks++;
            if (busy !== e_busy || req_ready !== e_ready || fifo_wreq !== e_wreq || fifo_wdata !== e_wdata || (e_busy && grant_id !== e_gid) || (fifo_wreq && fifo_wfull)) begin
                failures++;
                $display("FAIL stall_cycle: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want busy=%b ready=%b wreq=%b wdata=%h gid=%0d",
                         busy, req_ready, fifo_wreq, fifo_wdata, grant_id, e_busy, e_ready, e_wreq, e_wdata, e_gid);
            end
            if (c == 13) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_idle_hold: got busy=%b want 1", busy);
                end
            end
            if (fifo_wreq) begin
                wr_q.push_back(fifo_wdata);
                beat++;
            end
            advance();
        end
        fifo_wfull = 1'b0;
        checks++;
        if (wr_q.size() != 4 || wr_q[0] !== 8'h40 || wr_q[3] !== 8'h43) begin
            failures++;
            $display("FAIL stall_beats: got %0d beats want 4 (0x40..0x43)", wr_q.size());
        end
    endtask

    task automatic test_timeout();
        bit seen = 0;
        int cnt3 = 0;
        int first0 = -1;
        drain();
        req_last = '0;
        req_valid = 4'b1000;
        req_data = $urandom;
        for (int c = 0; c < 6 && !seen; c++) begin
            sample();
            checks++;
            if (busy !== e_busy || req_ready !== e_ready || fifo_wreq !== e_wreq || fifo_wdata !== e_wdata || (e_busy && grant_id !== e_gid) || (fifo_wreq && fifo_wfull)) begin
                failures++;
                $display("FAIL timeout_cycle: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want busy=%b ready=%b wreq=%b wdata=%h gid=%0d",
                         busy, req_ready, fifo_wreq, fifo_wdata, grant_id, e_busy, e_ready, e_wreq, e_wdata, e_gid);
            end
            if (fifo_wreq) seen = 1;
            advance();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL timeout_first_beat: got no beat within 6 cycles want one");
        end
        req_valid = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            sample();
            checks++;
            if (busy !== e_busy || req_ready !== e_ready || fifo_wreq !== e_wreq || fifo_wdata !== e_wdata || (e_busy && grant_id !== e_gid) || (fifo_wreq && fifo_wfull)) begin
                failures++;
                $display("FAIL timeout_cycle: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want busy=%b ready=%b wreq=%b wdata=%h gid=%0d",
                         busy, req_ready, fifo_wreq, fifo_wdata, grant_id, e_busy, e_ready, e_wreq, e_wdata, e_gid);
            end
            if (busy && grant_id == 2'd3) cnt3++;
            if (busy && grant_id == 2'd0 && first0 < 0) first0 = c;
            advance();
        end
        checks++;
        if (cnt3 != 8 || first0 != 9) begin
            failures++;
            $display("FAIL timeout_release: got idle_busy=%0d next_grant_at=%0d want 8 and 9", cnt3, first0);
        end
    endtask

    task automatic test_arb_en();
        int busy_off = 0;
        int g1 = -1;
        logic b11 = 1'b0;
        logic b12 = 1'b0;
        logic [1:0] g12 = '0;
        drain();
        req_last = '0;
        req_valid = 4'b0011;
        for (int c = 0; c <= 12; c++) begin
            arb_en = (c == 0 || c >= 11);
            req_data = $urandom;
            sample();
            checks++;
            if (busy !== e_busy || req_ready !== e_ready || fifo_wreq !== e_wreq || fifo_wdata !== e_wdata || (e_busy && grant_id !== e_gid) || (fifo_wreq && fifo_wfull)) begin
                failures++;
                $display("FAIL arb_en_cycle: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want busy=%b ready=%b wreq=%b wdata=%h gid=%0d",
                         busy, req_ready, fifo_wreq, fifo_wdata, grant_id, e_busy, e_ready, e_wreq, e_wdata, e_gid);
            end
            if (c == 1) g1 = int'(grant_id);
            if (c >= 1 && c <= 10 && busy) busy_off++;
            if (c == 11) b11 = busy;
            if (c == 12) begin b12 = busy; g12 = grant_id; end
            advance();
        end
        arb_en = 1'b1;
        checks++;
        if (busy_off != 4 || b11 !== 1'b0 || b12 !== 1'b1 || int'(g12) != (g1 ^ 1)) begin
            failures++;
            $display("FAIL arb_en_hold: got burst_cycles=%0d busy11=%b busy12=%b gid=%0d want 4,0,1,%0d",
                     busy_off, b11, b12, g12, g1 ^ 1);
        end
    endtask

    task automatic test_reset_mid_burst();
        int first_g = -1;
        drain();
        arb_en = 1'b1; req_last = '0; req_valid = 4'b1100; req_data = $urandom;
        for (int c = 0; c < 3; c++) advance();
        #2 wrst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'h0 || fifo_wreq !== 1'b0 || fifo_wdata !== 8'h00 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_burst: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want all zero",
                     busy, req_ready, fifo_wreq, fifo_wdata, grant_id);
        end
        model_reset();
        @(posedge wclk);
        #1;
        wrst_n = 1'b1; req_valid = 4'hF; req_last = 4'hF;
        for (int c = 0; c < 4; c++) begin
            sample();
            checks++;
            if (busy !== e_busy || req_ready !== e_ready || fifo_wreq !== e_wreq || fifo_wdata !== e_wdata || (e_busy && grant_id !== e_gid) || (fifo_wreq && fifo_wfull)) begin
                failures++;
                $display("FAIL reset_resume_cycle: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want busy=%b ready=%b wreq=%b wdata=%h gid=%0d",
                         busy, req_ready, fifo_wreq, fifo_wdata, grant_id, e_busy, e_ready, e_wreq, e_wdata, e_gid);
            end
            if (busy && first_g < 0) first_g = int'(grant_id);
            advance();
        end
        checks++;
        if (first_g != 0) begin
            failures++;
            $display("FAIL reset_first_grant: got %0d want 0", first_g);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            arb_en     = ($urandom_range(0, 7) != 0);
            req_valid  = 4'($urandom);
            req_last   = 4'($urandom) & 4'($urandom);
            req_data   = $urandom;
            fifo_wfull = ($urandom_range(0, 4) == 0);
            sample();
            checks++;
            if (busy !== e_busy || req_ready !== e_ready || fifo_wreq !== e_wreq || fifo_wdata !== e_wdata || (e_busy && grant_id !== e_gid) || (fifo_wreq && fifo_wfull)) begin
                failures++;
                $display("FAIL random_cycle %0d: got busy=%b ready=%b wreq=%b wdata=%h gid=%0d want busy=%b ready=%b wreq=%b wdata=%h gid=%0d",
                         c, busy, req_ready, fifo_wreq, fifo_wdata, grant_id, e_busy, e_ready, e_wreq, e_wdata, e_gid);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stream_cap();
        test_wfull_stall();
        test_timeout();
        test_arb_en();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
